// File: rtl/pic_pkg.sv
// Shared constants and types for the pic_intc interrupt controller.
package pic_pkg;

  localparam logic [1:0] WA_IMR   = 2'd0;
  localparam logic [1:0] WA_CTRL  = 2'd1;
  localparam logic [1:0] WA_VBASE = 2'd2;
  localparam logic [1:0] WA_EOI   = 2'd3;

  localparam logic [1:0] RA_IMR = 2'd0;
  localparam logic [1:0] RA_IRR = 2'd1;
  localparam logic [1:0] RA_ISR = 2'd2;
  localparam logic [1:0] RA_CFG = 2'd3;

  localparam int CTRL_LTIM = 0;
  localparam int CTRL_ROT  = 1;
  localparam int CTRL_AEOI = 2;
  localparam int CTRL_W    = 3;

  localparam logic [7:0] VBASE_RST = 8'h20;

  typedef enum logic [1:0] {IDLE, REQ, VEC} state_t;

endpackage

// File: rtl/pic_prio_res.sv
// Rotating find-first: returns the first set bit scanning upward from ptr+1
// with wrap-around.
module pic_prio_res #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] vec,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W:0] pos;

  // Scan from lowest priority to highest so the last hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      pos = (IDX_W+1)'(ptr) + (IDX_W+1)'(k) + (IDX_W+1)'(1);
      if (pos >= (IDX_W+1)'(NUM_IRQ)) pos = pos - (IDX_W+1)'(NUM_IRQ);
      if (vec[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pic_intc.sv
// Programmable interrupt controller: request latching, masking, nested
// priority resolution and INT/INTA vector handshake.
module pic_intc
  import pic_pkg::*;
#(
  parameter int  NUM_IRQ = 8,
  localparam int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic [1:0]         rd_addr,
  output logic [31:0]        rd_data,
  output logic               int_o,
  input  logic               inta_i,
  output logic [7:0]         vec_o,
  output logic               vec_valid_o
);

  logic [NUM_IRQ-1:0] imr_reg, irr_reg, isr_reg, irq_prev_reg;
  logic [NUM_IRQ-1:0] irr_next, isr_next, irr_ack_clr, isr_ack_set, isr_eoi_clr;
  logic [CTRL_W-1:0]  ctrl_reg;
  logic [7:0]         vbase_reg, vec_reg;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  state_t             state_reg;
  logic               int_reg, vec_valid_reg;

  logic               cand_found, isr_found, qualify, ack_real;
  logic [IDX_W-1:0]   cand_idx, isr_idx, eoi_idx, spec_idx;
  logic               eoi_hit, spec_in_range;
  logic               ltim, rot, aeoi;
  logic               unused_wr_data;

  assign ltim = ctrl_reg[CTRL_LTIM];
  assign rot  = ctrl_reg[CTRL_ROT];
  assign aeoi = ctrl_reg[CTRL_AEOI];
  assign unused_wr_data = ^wr_data;

  pic_prio_res #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_req_res (
    .vec   (irr_reg & ~imr_reg),
    .ptr   (ptr_reg),
    .found (cand_found),
    .idx   (cand_idx)
  );

  pic_prio_res #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_isr_res (
    .vec   (isr_reg),
    .ptr   (ptr_reg),
    .found (isr_found),
    .idx   (isr_idx)
  );

  // Distance of an index from the current top-priority slot (0 = highest).
  function automatic logic [IDX_W:0] rank_of(input logic [IDX_W-1:0] i,
                                             input logic [IDX_W-1:0] p);
    if (i > p) return {1'b0, i} - {1'b0, p} - (IDX_W+1)'(1);
    else       return {1'b0, i} + (IDX_W+1)'(NUM_IRQ) - {1'b0, p} - (IDX_W+1)'(1);
  endfunction

  assign qualify  = cand_found &&
                    (!isr_found || (rank_of(cand_idx, ptr_reg) < rank_of(isr_idx, ptr_reg)));
  assign ack_real = (state_reg == REQ) && inta_i && qualify;

  assign spec_idx      = wr_data[IDX_W-1:0];
  assign spec_in_range = ({1'b0, spec_idx} < (IDX_W+1)'(NUM_IRQ));

  always_comb begin
    eoi_idx = isr_idx;
    eoi_hit = 1'b0;
    if (wr_en && wr_addr == WA_EOI) begin
      if (wr_data[31]) begin
        eoi_idx = spec_idx;
        eoi_hit = spec_in_range && isr_reg[spec_idx];
      end else begin
        eoi_hit = isr_found;
      end
    end
  end

  assign isr_eoi_clr = eoi_hit ? (NUM_IRQ'(1) << eoi_idx) : '0;
  assign isr_ack_set = (ack_real && !aeoi) ? (NUM_IRQ'(1) << cand_idx) : '0;
  assign irr_ack_clr = (ack_real && !ltim) ? (NUM_IRQ'(1) << cand_idx) : '0;
  // EOI clear lands before the acknowledge set when both happen together.
  assign isr_next    = (isr_reg & ~isr_eoi_clr) | isr_ack_set;

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_irr
    assign irr_next[gi] = ltim ? irq_i[gi]
                               : (irq_i[gi] && (irr_reg[gi] || !irq_prev_reg[gi]) && !irr_ack_clr[gi]);
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (eoi_hit && rot)           ptr_next = eoi_idx;
    if (ack_real && aeoi && rot)  ptr_next = cand_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imr_reg      <= '1;
      irr_reg      <= '0;
      isr_reg      <= '0;
      irq_prev_reg <= '0;
      ctrl_reg     <= '0;
      vbase_reg    <= VBASE_RST;
      ptr_reg      <= IDX_W'(NUM_IRQ - 1);
    end else begin
      irr_reg      <= irr_next;
      isr_reg      <= isr_next;
      irq_prev_reg <= irq_i;
      ptr_reg      <= ptr_next;
      if (wr_en) begin
        case (wr_addr)
          WA_IMR:   imr_reg   <= wr_data[NUM_IRQ-1:0];
          WA_CTRL:  ctrl_reg  <= wr_data[CTRL_W-1:0];
          WA_VBASE: vbase_reg <= wr_data[7:0];
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      int_reg       <= 1'b0;
      vec_reg       <= '0;
      vec_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          vec_valid_reg <= 1'b0;
          if (qualify) begin
            state_reg <= REQ;
            int_reg   <= 1'b1;
          end
        end
        REQ: begin
          if (inta_i) begin
            state_reg     <= VEC;
            int_reg       <= 1'b0;
            vec_valid_reg <= 1'b1;
            vec_reg       <= qualify ? (vbase_reg + 8'(cand_idx))
                                     : (vbase_reg + 8'(NUM_IRQ - 1));
          end else if (!qualify) begin
            state_reg <= IDLE;
            int_reg   <= 1'b0;
          end
        end
        VEC: begin
          vec_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      RA_IMR:  rd_data[NUM_IRQ-1:0] = imr_reg;
      RA_IRR:  rd_data[NUM_IRQ-1:0] = irr_reg;
      RA_ISR:  rd_data[NUM_IRQ-1:0] = isr_reg;
      default: rd_data[CTRL_W+7:0]  = {ctrl_reg, vbase_reg};
    endcase
  end

  assign int_o       = int_reg;
  assign vec_o       = vec_reg;
  assign vec_valid_o = vec_valid_reg;

endmodule

// File: doc/pic_intc.md
Name: pic_intc

Overview:
- Synchronous, parametrised programmable interrupt controller; next generation of the team's 8-input PIC.
- Latches NUM_IRQ request lines (edge or level), masks them, and resolves priority (fixed or rotating) against in-service levels (fully nested).
- Drives an INT/INTA handshake to the CPU and returns a vector.
- Sits between peripheral IRQ lines and the CPU interrupt port; programmed over a simple register write/read port.

Parameters:
- NUM_IRQ, 8, number of request lines, legal range 2..32.
- IDX_W, $clog2(NUM_IRQ), width of an IRQ index (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- irq_i  input  NUM_IRQ  request lines, already synchronised to clk.
- wr_en  input  1  register write strobe, one cycle.
- wr_addr  input  2  write address: 0 IMR, 1 CTRL, 2 VBASE, 3 EOI.
- wr_data  input  32  write data.
- rd_addr  input  2  read address: 0 IMR, 1 IRR, 2 ISR, 3 {CTRL, VBASE}.
- rd_data  output  32  combinational read data; unused upper bits read 0.
- int_o  output  1  interrupt request to CPU, registered.
- inta_i  input  1  acknowledge, one-cycle pulse.
- vec_o  output  8  vector, valid while vec_valid_o is high.
- vec_valid_o  output  1  one-cycle strobe, exactly one cycle after the accepted inta_i.

Behaviour:
Reset values:
- IMR = all 1 (everything masked); IRR = 0; ISR = 0.
- CTRL = 0: edge mode, fixed priority, normal EOI.
- VBASE = 0x20; priority pointer = NUM_IRQ-1, so IRQ0 is highest.
- int_o = 0, vec_o = 0, vec_valid_o = 0, state = IDLE.
- Reset asserted mid-handshake aborts it; no vector is issued.

Registers:
- CTRL bit0 LTIM: 1 = level mode.
- CTRL bit1 ROT: 1 = rotating priority.
- CTRL bit2 AEOI.
- VBASE is 8 bits.

IRR:
- Edge mode: bit i sets on a rising edge of irq_i[i] (previous-cycle sample 0, now 1). It clears on acknowledge of i, or when irq_i[i] drops before acknowledge.
- Level mode: IRR bit i follows irq_i[i] directly.
- Masking never alters IRR.

Priority:
- Highest priority is index (ptr+1) mod NUM_IRQ, then ascending with wrap-around.
- cand = highest-priority bit of IRR & ~IMR.
- A request qualifies if ISR is empty, or cand outranks the highest-priority ISR bit.

FSM:
- IDLE: go to REQ when a request qualifies; int_o = 1 from the next cycle.
- REQ: go back to IDLE, dropping int_o, if no request qualifies and inta_i is low. On inta_i, capture cand, or flag spurious if none qualifies, and go to VEC; int_o = 0.
- VEC: vec_valid_o = 1 for one cycle, then go to IDLE.
- inta_i while in IDLE or VEC is ignored.

Acknowledge, applied on the inta_i edge:
- Clear IRR[cand] (edge mode only).
- Without AEOI: set ISR[cand].
- With AEOI: leave ISR unchanged; if ROT, set ptr = cand.
- vec_o = VBASE + cand, 8-bit wrap-around.
- Spurious: vec_o = VBASE + NUM_IRQ-1; IRR and ISR unchanged.

EOI (write to addr 3):
- wr_data[31]=1: specific EOI, clears ISR[wr_data[IDX_W-1:0]].
- wr_data[31]=0: non-specific EOI, clears the highest-priority ISR bit.
- If ROT is set, ptr = the cleared index.
- EOI with ISR empty is a no-op.

Simultaneous events:
- EOI write and acknowledge in the same cycle: the acknowledge uses pre-EOI ISR for arbitration; both updates apply, with the EOI clear applied before the set.
- IMR write in the same cycle as inta_i: the acknowledge uses the old IMR.
- Out-of-range specific-EOI index is ignored.

Decomposition:
- Package pic_pkg holds:
  - register address constants (IMR, CTRL, VBASE, EOI, IRR/ISR read addresses);
  - CTRL bit positions;
  - state enum (IDLE, REQ, VEC);
  - reset constants (VBASE 0x20).
- One sub-module, pic_prio_res: combinational rotating find-first.
  - Inputs: NUM_IRQ-bit vector, ptr.
  - Outputs: found flag, IDX_W index.
  - Instantiated twice: for IRR & ~IMR and for ISR.

Test Plan:
- Reset, then read all registers -> IMR=0xFF, IRR=0, ISR=0, rd_addr 3 returns VBASE 0x20; int_o=0.
- IMR=0, edge pulse on IRQ3 -> int_o high 1 cycle later. inta_i -> next cycle vec_valid_o=1, vec_o=0x23, ISR=0x08, IRR=0.
- Nesting: IRQ5 in service, raise IRQ6 -> int_o stays 0. Raise IRQ2 -> int_o=1, ack gives vec 0x22, ISR=0x24. Non-specific EOI -> ISR=0x20.
- Rotation (ROT=1): service and EOI IRQ0, then raise IRQ0 and IRQ4 together -> IRQ4 acknowledged first (vec 0x24).
- Level mode plus AEOI, IRQ7 held high: ack -> vec 0x27, ISR stays 0, int_o reasserts. Drop IRQ7 while int_o=1 -> int_o falls, and inta_i then returns spurious vec 0x27 with ISR unchanged.
- Assert reset in VEC state -> vec_valid_o=0 immediately, all registers back to reset values.
